// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target bridge.
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_e;

    typedef enum logic [1:0] {
        COND_NONE,
        COND_START,
        COND_STOP
    } bus_cond_e;

    // Level on SDA that means "acknowledge".
    localparam logic SDA_ACK = 1'b0;

    // bit_cnt values: 8 = byte shifted in/out, 9 = inside the ACK clock.
    localparam logic [3:0] BYTE_BITS = 4'd8;
    localparam logic [3:0] ACK_SLOT  = 4'd9;

    // SDA moving while SCL is high is a bus condition, never data.
    function automatic bus_cond_e bus_cond(input logic scl_lvl, input logic sda_rise,
                                           input logic sda_fall);
        if (scl_lvl && sda_fall) return COND_START;
        if (scl_lvl && sda_rise) return COND_STOP;
        return COND_NONE;
    endfunction

endpackage

// File: rtl/i2c_slave_filter.sv
// Synchroniser, stability filter and edge detector for one I2C line.
module i2c_slave_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    // Accept a new level only after it has differed for FILTER_LEN consecutive clks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Lines idle high; resetting to 1 avoids a false edge when reset releases.
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere so each flop sees pre-edge values of the others.
            sync_q <= {sync_q[0], line_i};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_q <= sync_q[1];
                rise_q  <= sync_q[1];
                fall_q  <= ~sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_bridge.sv
// I2C target exposing an 8-bit register space through write strobes and read requests.
module i2c_slave_bridge
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         PTR_W      = 8,
    parameter int         FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             axi_reset_n,
    input  logic             scl_pad_i,
    output logic             scl_pad_o,
    output logic             scl_padoen_o,
    input  logic             sda_pad_i,
    output logic             sda_pad_o,
    output logic             sda_padoen_o,
    output logic             o_wr_valid,
    output logic [PTR_W-1:0] o_wr_addr,
    output logic [7:0]       o_wr_data,
    output logic             o_rd_req,
    output logic [PTR_W-1:0] o_rd_addr,
    input  logic [7:0]       i_rd_data,
    output logic             o_busy
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk(clk), .rst_n(axi_reset_n), .line_i(scl_pad_i),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk(clk), .rst_n(axi_reset_n), .line_i(sda_pad_i),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    state_e           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rw_q, rw_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             wr_valid_q, wr_valid_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             rd_req_q, rd_req_d;
    logic [PTR_W-1:0] rd_addr_q, rd_addr_d;
    bus_cond_e        cond;

    // Next-state logic: bus conditions first, then per-state bit/ACK handling on SCL edges.
    always_comb begin
        // NOTE: every _d takes its held value first, so no path can infer a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_req_d   = 1'b0;
        rd_addr_d  = rd_addr_q;
        cond       = bus_cond(scl_lvl, sda_rise, sda_fall);

        // Read data is valid the clk after the request.
        if (rd_req_q) shift_d = i_rd_data;

        if (cond == COND_START) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (cond == COND_STOP) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && bit_cnt_q < BYTE_BITS) begin
                        shift_d   = {shift_q[6:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == BYTE_BITS) begin
                        bit_cnt_d = ACK_SLOT;
                        if (state_q != ST_ADDR) begin
                            sda_oe_d = 1'b1;
                        end else if (shift_q[7:1] == SLAVE_ADDR) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_rise && bit_cnt_q == ACK_SLOT) begin
                        if (state_q == ST_PTR) begin
                            ptr_d = PTR_W'(shift_q);
                        end else begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = shift_q;
                            ptr_d      = ptr_q + PTR_W'(1);
                        end
                    end else if (scl_fall && bit_cnt_q == ACK_SLOT) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_WDATA;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise && rw_q) begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = ptr_q;
                    end else if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d  = ST_RDATA;
                            sda_oe_d = ~shift_q[7];
                        end else begin
                            state_d  = ST_PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise && bit_cnt_q < BYTE_BITS) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q != 4'd0 && bit_cnt_q < BYTE_BITS) begin
                        sda_oe_d = ~shift_q[6];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end else if (scl_fall && bit_cnt_q == BYTE_BITS) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = ACK_SLOT;
                    end else if (scl_rise && bit_cnt_q == ACK_SLOT) begin
                        if (sda_lvl == SDA_ACK) begin
                            ptr_d     = ptr_q + PTR_W'(1);
                            rd_req_d  = 1'b1;
                            rd_addr_d = ptr_q + PTR_W'(1);
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && bit_cnt_q == ACK_SLOT) begin
                        sda_oe_d  = ~shift_q[7];
                        bit_cnt_d = '0;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers; reset releases SDA asynchronously.
    always_ff @(posedge clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    assign scl_pad_o    = 1'b0;
    assign scl_padoen_o = 1'b1;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = ~sda_oe_q;
    assign o_wr_valid   = wr_valid_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_rd_req     = rd_req_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_bridge.sv
// Bus-level bench: a bit-banged I2C master drives the target; a register-space model predicts results.
module tb_i2c_slave_bridge;
    localparam int         T_Q    = 10;
    localparam int         T_H    = 20;
    localparam logic [7:0] ADDR_W = 8'hA0;
    localparam logic [7:0] ADDR_R = 8'hA1;

    logic       clk = 1'b0;
    logic       axi_reset_n = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
    logic       o_wr_valid, o_rd_req, o_busy;
    logic [7:0] o_wr_addr, o_wr_data, o_rd_addr, i_rd_data;

    wire sda_line = sda_m & (sda_padoen_o | sda_pad_o);
    wire scl_line = scl_m & (scl_padoen_o | scl_pad_o);

    // Register space returns the inverted address.
    assign i_rd_data = ~o_rd_addr;

    always #5 clk = ~clk;

    i2c_slave_bridge dut (
        .clk(clk), .axi_reset_n(axi_reset_n),
        .scl_pad_i(scl_line), .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
        .sda_pad_i(sda_line), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
        .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_busy(o_busy)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  m_ptr = 8'h00;
    logic [7:0]  wdat [4];
    logic [7:0]  rdat [4];
    logic [15:0] wr_log [$];
    logic [7:0]  rd_log [$];
    int          both_cnt = 0;
    int          oe_low_cnt = 0;

    // Record every strobe and every cycle the target pulls SDA.
    always @(negedge clk) begin
        if (o_wr_valid) wr_log.push_back({o_wr_addr, o_wr_data});
        if (o_rd_req) rd_log.push_back(o_rd_addr);
        if (o_wr_valid && o_rd_req) both_cnt++;
        if (!sda_padoen_o) oe_low_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(T_Q);
        scl_m = 1'b1; tick(T_Q);
        sda_m = 1'b0; tick(T_Q);
        scl_m = 1'b0; tick(T_Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(T_Q);
        scl_m = 1'b1; tick(T_Q);
        sda_m = 1'b1; tick(T_Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick(T_Q);
            scl_m = 1'b1; tick(T_H);
            scl_m = 1'b0; tick(T_Q);
        end
        sda_m = 1'b1; tick(T_Q);
        scl_m = 1'b1; tick(T_Q);
        acked = ~sda_line;
        tick(T_Q);
        scl_m = 1'b0; tick(T_Q);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(T_Q);
            scl_m = 1'b1; tick(T_Q);
            b[i] = sda_line;
            tick(T_Q);
            scl_m = 1'b0;
        end
        tick(T_Q);
        sda_m = ~ack;
        tick(T_Q);
        scl_m = 1'b1; tick(T_H);
        scl_m = 1'b0; tick(T_Q);
        sda_m = 1'b1;
    endtask

    task automatic xfer_write(input logic [7:0] p, input int n, output int n_ack,
                              output logic busy_mid);
        logic a;
        n_ack = 0;
        bus_start();
        write_byte(ADDR_W, a); n_ack += int'(a);
        busy_mid = o_busy;
        write_byte(p, a); n_ack += int'(a);
        for (int k = 0; k < n; k++) begin
            write_byte(wdat[k], a); n_ack += int'(a);
        end
        bus_stop();
    endtask

    task automatic xfer_read(input logic set_ptr, input logic [7:0] p, input int n,
                             output int n_ack, output logic oe_after);
        logic       a;
        logic [7:0] b;
        n_ack = 0;
        bus_start();
        if (set_ptr) begin
            write_byte(ADDR_W, a); n_ack += int'(a);
            write_byte(p, a); n_ack += int'(a);
            bus_start();
        end
        write_byte(ADDR_R, a); n_ack += int'(a);
        for (int k = 0; k < n; k++) begin
            read_byte(k != n - 1, b);
            rdat[k] = b;
        end
        oe_after = sda_padoen_o;
        bus_stop();
    endtask

    task automatic test_reset();
        tick(2);
        axi_reset_n = 1'b0;
        tick(5);
        n_checks++;
        if (sda_padoen_o !== 1'b1) $display("FAIL reset_sda_oen got=%b exp=1", sda_padoen_o);
        else n_pass++;
        n_checks++;
        if ({o_wr_valid, o_rd_req, o_busy} !== 3'b000)
            $display("FAIL reset_strobes got=%b exp=000", {o_wr_valid, o_rd_req, o_busy});
        else n_pass++;
        n_checks++;
        if ({o_wr_addr, o_wr_data, o_rd_addr} !== 24'h0)
            $display("FAIL reset_addr_data got=%h exp=0", {o_wr_addr, o_wr_data, o_rd_addr});
        else n_pass++;
        n_checks++;
        if ({scl_padoen_o, scl_pad_o, sda_pad_o} !== 3'b100)
            $display("FAIL reset_pad_ties got=%b exp=100", {scl_padoen_o, scl_pad_o, sda_pad_o});
        else n_pass++;
        axi_reset_n = 1'b1;
        tick(10);
    endtask

    task automatic test_single_write();
        int   n_ack;
        logic busy_mid;
        int   wb;
        wb = wr_log.size();
        wdat[0] = 8'h5A;
        xfer_write(8'h10, 1, n_ack, busy_mid);
        m_ptr = 8'h11;
        n_checks++;
        if (n_ack !== 3) $display("FAIL single_write_acks got=%0d exp=3", n_ack);
        else n_pass++;
        n_checks++;
        if (busy_mid !== 1'b1) $display("FAIL single_write_busy_mid got=%b exp=1", busy_mid);
        else n_pass++;
        n_checks++;
        if (wr_log.size() - wb !== 1)
            $display("FAIL single_write_count got=%0d exp=1", wr_log.size() - wb);
        else n_pass++;
        n_checks++;
        if (wr_log.size() <= wb || wr_log[wb] !== 16'h105A)
            $display("FAIL single_write_entry got=%h exp=105a",
                     (wr_log.size() > wb) ? wr_log[wb] : 16'hxxxx);
        else n_pass++;
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL single_write_busy_after_stop got=%b exp=0", o_busy);
        else n_pass++;
    endtask

    task automatic test_ptr_wrap();
        int          n_ack;
        logic        busy_mid;
        int          wb;
        logic [15:0] got;
        logic [15:0] exp_e [2];
        exp_e[0] = 16'hFF11;
        exp_e[1] = 16'h0022;
        wb = wr_log.size();
        wdat[0] = 8'h11;
        wdat[1] = 8'h22;
        xfer_write(8'hFF, 2, n_ack, busy_mid);
        m_ptr = 8'h01;
        n_checks++;
        if (wr_log.size() - wb !== 2) $display("FAIL wrap_count got=%0d exp=2", wr_log.size() - wb);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            got = (wr_log.size() > wb + k) ? wr_log[wb + k] : 16'hxxxx;
            n_checks++;
            if (got !== exp_e[k]) $display("FAIL wrap_entry%0d got=%h exp=%h", k, got, exp_e[k]);
            else n_pass++;
        end
    endtask

    task automatic test_combined_read();
        int         n_ack;
        logic       oe_after;
        int         rb;
        logic [7:0] got;
        rb = rd_log.size();
        xfer_read(1'b1, 8'h10, 2, n_ack, oe_after);
        m_ptr = 8'h11;
        n_checks++;
        if (n_ack !== 3) $display("FAIL comb_read_acks got=%0d exp=3", n_ack);
        else n_pass++;
        n_checks++;
        if (rdat[0] !== 8'hEF) $display("FAIL comb_read_byte0 got=%h exp=ef", rdat[0]);
        else n_pass++;
        n_checks++;
        if (rdat[1] !== 8'hEE) $display("FAIL comb_read_byte1 got=%h exp=ee", rdat[1]);
        else n_pass++;
        got = (rd_log.size() > rb) ? rd_log[rb] : 8'hxx;
        n_checks++;
        if (got !== 8'h10) $display("FAIL comb_read_addr0 got=%h exp=10", got);
        else n_pass++;
        got = (rd_log.size() > rb + 1) ? rd_log[rb + 1] : 8'hxx;
        n_checks++;
        if (got !== 8'h11) $display("FAIL comb_read_addr1 got=%h exp=11", got);
        else n_pass++;
        n_checks++;
        if (oe_after !== 1'b1) $display("FAIL comb_read_release_after_nack got=%b exp=1", oe_after);
        else n_pass++;
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1, busy_mid;
        int   wb, rb, ob;
        wb = wr_log.size();
        rb = rd_log.size();
        ob = oe_low_cnt;
        bus_start();
        write_byte(8'hA2, a0);
        busy_mid = o_busy;
        write_byte(8'h10, a1);
        bus_stop();
        n_checks++;
        if ({a0, a1} !== 2'b00) $display("FAIL mismatch_acks got=%b exp=00", {a0, a1});
        else n_pass++;
        n_checks++;
        if (oe_low_cnt - ob !== 0) $display("FAIL mismatch_sda_driven got=%0d exp=0", oe_low_cnt - ob);
        else n_pass++;
        n_checks++;
        if ((wr_log.size() - wb) + (rd_log.size() - rb) !== 0)
            $display("FAIL mismatch_strobes got=%0d exp=0",
                     (wr_log.size() - wb) + (rd_log.size() - rb));
        else n_pass++;
        n_checks++;
        if ({busy_mid, o_busy} !== 2'b00) $display("FAIL mismatch_busy got=%b exp=00", {busy_mid, o_busy});
        else n_pass++;
    endtask

    task automatic test_glitch();
        logic a;
        int   ob;
        ob = oe_low_cnt;
        sda_m = 1'b0; tick(1);
        sda_m = 1'b1; tick(20);
        sda_m = 1'b0; tick(2);
        sda_m = 1'b1; tick(20);
        // Without a real START, a matching address byte must be ignored.
        scl_m = 1'b0; tick(T_Q);
        write_byte(ADDR_W, a);
        n_checks++;
        if (a !== 1'b0) $display("FAIL glitch_ack got=%b exp=0", a);
        else n_pass++;
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL glitch_busy got=%b exp=0", o_busy);
        else n_pass++;
        n_checks++;
        if (oe_low_cnt - ob !== 0) $display("FAIL glitch_sda_driven got=%0d exp=0", oe_low_cnt - ob);
        else n_pass++;
        bus_stop();
    endtask

    task automatic test_random();
        for (int it = 0; it < 14; it++) begin
            int          kind, n, n_ack, wb, rb;
            logic [7:0]  p, ea;
            logic [15:0] gw;
            logic [7:0]  gr;
            logic        busy_mid, oe_after;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                p = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 255));
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) wdat[k] = 8'($urandom_range(0, 255));
                wb = wr_log.size();
                xfer_write(p, n, n_ack, busy_mid);
                n_checks++;
                if (n_ack !== n + 2) $display("FAIL rnd%0d_wr_acks got=%0d exp=%0d", it, n_ack, n + 2);
                else n_pass++;
                n_checks++;
                if (wr_log.size() - wb !== n)
                    $display("FAIL rnd%0d_wr_count got=%0d exp=%0d", it, wr_log.size() - wb, n);
                else n_pass++;
                for (int k = 0; k < n; k++) begin
                    ea = p + 8'(k);
                    gw = (wr_log.size() > wb + k) ? wr_log[wb + k] : 16'hxxxx;
                    n_checks++;
                    if (gw !== {ea, wdat[k]})
                        $display("FAIL rnd%0d_wr%0d got=%h exp=%h", it, k, gw, {ea, wdat[k]});
                    else n_pass++;
                end
                m_ptr = p + 8'(n);
            end else begin
                p = 8'($urandom_range(0, 255));
                if (kind == 2) m_ptr = p;
                n = $urandom_range(1, 3);
                rb = rd_log.size();
                xfer_read(kind == 2, p, n, n_ack, oe_after);
                n_checks++;
                if (n_ack !== ((kind == 2) ? 3 : 1))
                    $display("FAIL rnd%0d_rd_acks got=%0d exp=%0d", it, n_ack, (kind == 2) ? 3 : 1);
                else n_pass++;
                n_checks++;
                if (rd_log.size() - rb !== n)
                    $display("FAIL rnd%0d_rd_count got=%0d exp=%0d", it, rd_log.size() - rb, n);
                else n_pass++;
                for (int k = 0; k < n; k++) begin
                    ea = m_ptr + 8'(k);
                    n_checks++;
                    if (rdat[k] !== ~ea) $display("FAIL rnd%0d_rd_byte%0d got=%h exp=%h", it, k, rdat[k], ~ea);
                    else n_pass++;
                    gr = (rd_log.size() > rb + k) ? rd_log[rb + k] : 8'hxx;
                    n_checks++;
                    if (gr !== ea) $display("FAIL rnd%0d_rd_addr%0d got=%h exp=%h", it, k, gr, ea);
                    else n_pass++;
                end
                n_checks++;
                if (oe_after !== 1'b1) $display("FAIL rnd%0d_rd_release got=%b exp=1", it, oe_after);
                else n_pass++;
                m_ptr = m_ptr + 8'(n - 1);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int         n_ack, rb;
        logic       busy_mid, oe_after, a;
        logic [7:0] gr;
        xfer_write(8'h80, 0, n_ack, busy_mid);
        bus_start();
        write_byte(ADDR_R, a);
        // First data bit is bit 7 of ~0x80, a 0, so the target is pulling SDA now.
        n_checks++;
        if (sda_padoen_o !== 1'b0) $display("FAIL midread_driving_zero got=%b exp=0", sda_padoen_o);
        else n_pass++;
        axi_reset_n = 1'b0;
        #1;
        n_checks++;
        if (sda_padoen_o !== 1'b1) $display("FAIL midread_reset_release got=%b exp=1", sda_padoen_o);
        else n_pass++;
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL midread_reset_busy got=%b exp=0", o_busy);
        else n_pass++;
        tick(4);
        axi_reset_n = 1'b1;
        m_ptr = 8'h00;
        tick(4);
        bus_stop();
        rb = rd_log.size();
        xfer_read(1'b0, 8'h00, 1, n_ack, oe_after);
        n_checks++;
        if (rdat[0] !== 8'hFF) $display("FAIL midread_ptr_zero_data got=%h exp=ff", rdat[0]);
        else n_pass++;
        gr = (rd_log.size() > rb) ? rd_log[rb] : 8'hxx;
        n_checks++;
        if (gr !== 8'h00) $display("FAIL midread_ptr_zero_addr got=%h exp=00", gr);
        else n_pass++;
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (both_cnt !== 0) $display("FAIL wr_rd_same_cycle got=%0d exp=0", both_cnt);
        else n_pass++;
        n_checks++;
        if ({o_busy, sda_padoen_o} !== 2'b01)
            $display("FAIL final_idle got=%b exp=01", {o_busy, sda_padoen_o});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_ptr_wrap();
        test_combined_read();
        test_addr_mismatch();
        test_glitch();
        test_random();
        test_reset_mid_read();
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
